// File: rtl/micro_sequencer_pkg.sv
// Shared opcode set and condition helper for the microprogram sequencer.
// Imported by the sequencer top level and its LIFO.
package micro_sequencer_pkg;

   localparam logic [3:0] OP_JZ   = 4'd0;
   localparam logic [3:0] OP_CJS  = 4'd1;
   localparam logic [3:0] OP_JMAP = 4'd2;
   localparam logic [3:0] OP_CJP  = 4'd3;
   localparam logic [3:0] OP_PUSH = 4'd4;
   localparam logic [3:0] OP_CRTN = 4'd5;
   localparam logic [3:0] OP_LDCT = 4'd6;
   localparam logic [3:0] OP_RPCT = 4'd7;
   localparam logic [3:0] OP_RFCT = 4'd8;
   localparam logic [3:0] OP_LOOP = 4'd9;
   localparam logic [3:0] OP_CASE = 4'd10;
   localparam logic [3:0] OP_CONT = 4'd11;

   function automatic logic cond_eval(
      input logic cond,
      input logic pol,
      input logic en
   );
      return en ? (cond ^ pol) : 1'b1;
   endfunction

endpackage

// File: rtl/micro_sequencer_seq_stack.sv
// Return-address LIFO for the sequencer.
// Overflow/underflow leave sp alone and raise a sticky err.
module seq_stack
   import micro_sequencer_pkg::*;
#(
   parameter int              DEPTH     = 4,
   parameter int              W         = 11,
   parameter logic [W-1:0]    EMPTY_VAL = '0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic         rd,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty,
   output logic         err
);

   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem [DEPTH];
   logic [SP_W-1:0]  sp;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;
   logic             do_push;
   logic             do_pop;
   logic             bad;

   assign full    = (sp == SP_W'(DEPTH));
   assign empty   = (sp == '0);
   assign wr_idx  = IDX_W'(sp);
   assign top_idx = IDX_W'(sp - SP_W'(1));
   assign top     = empty ? EMPTY_VAL : mem[top_idx];
   assign do_push = en & push & ~full;
   assign do_pop  = en & pop & ~empty;
   assign bad     = (push & full) | ((pop | rd) & empty);

   // Entry storage; contents after reset are don't-care
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_idx] <= din;
   end

   // Stack pointer and sticky error; clear beats a same-cycle error
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sp  <= '0;
         err <= 1'b0;
      end else if (en) begin
         if (clr) begin
            sp  <= '0;
            err <= 1'b0;
         end else begin
            if (do_push)     sp <= sp + SP_W'(1);
            else if (do_pop) sp <= sp - SP_W'(1);
            if (bad) err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next-address mux, uPC, loop counter.
// y feeds the microcode ROM address combinationally.
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter int                 ADDR_W      = 11,
   parameter int                 STACK_DEPTH = 4,
   parameter int                 CNT_W       = 8,
   parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] din,
   input  logic [ADDR_W-1:0] orin,
   input  logic [CNT_W-1:0]  cnt_in,
   input  logic              cond,
   input  logic              cond_pol,
   input  logic              cond_en,
   input  logic              hold,
   output logic [ADDR_W-1:0] y,
   output logic [ADDR_W-1:0] upc,
   output logic              cnt_zero,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_err
);

   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] top;
   logic              ce;
   logic              push;
   logic              pop;
   logic              rd;
   logic              clr;
   logic              ld;
   logic              dec;

   assign ce       = cond_eval(cond, cond_pol, cond_en);
   assign cnt_zero = (cnt == '0);

   // Next-address select and side-effect strobes per opcode
   always_comb begin
      y    = upc;
      push = 1'b0;
      pop  = 1'b0;
      rd   = 1'b0;
      clr  = 1'b0;
      ld   = 1'b0;
      dec  = 1'b0;
      unique case (1'b1)
         (op == OP_JZ): begin
            y   = RESET_ADDR;
            clr = 1'b1;
         end
         (op == OP_CJS): begin
            if (ce) begin
               y    = din;
               push = 1'b1;
            end
         end
         (op == OP_JMAP): y = din;
         (op == OP_CJP): begin
            if (ce) y = din;
         end
         (op == OP_PUSH): begin
            push = 1'b1;
            ld   = ce;
         end
         (op == OP_CRTN): begin
            if (ce) begin
               y   = top;
               pop = 1'b1;
            end
         end
         (op == OP_LDCT): ld = 1'b1;
         (op == OP_RPCT): begin
            if (!cnt_zero) begin
               y   = din;
               dec = 1'b1;
            end
         end
         (op == OP_RFCT): begin
            if (!cnt_zero) begin
               y   = top;
               rd  = 1'b1;
               dec = 1'b1;
            end else begin
               pop = 1'b1;
            end
         end
         (op == OP_LOOP): begin
            if (ce) begin
               pop = 1'b1;
            end else begin
               y  = top;
               rd = 1'b1;
            end
         end
         (op == OP_CASE): y = din | orin;
         default: y = upc;
      endcase
      if (!reset) y = RESET_ADDR;
   end

   // Microprogram counter follows y+1 unless stalled
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) upc <= RESET_ADDR + ADDR_W'(1);
      else if (!hold) upc <= y + ADDR_W'(1);
   end

   // Loop counter: load, or saturating decrement
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!hold) begin
         if (ld) cnt <= cnt_in;
         else if (dec && !cnt_zero) cnt <= cnt - CNT_W'(1);
      end
   end

   seq_stack #(
      .DEPTH     (STACK_DEPTH),
      .W         (ADDR_W),
      .EMPTY_VAL (RESET_ADDR)
   ) u_stack (
      .clock (clock),
      .reset (reset),
      .en    (~hold),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .rd    (rd),
      .din   (upc),
      .top   (top),
      .full  (stack_full),
      .empty (stack_empty),
      .err   (stack_err)
   );

endmodule
